// File: rtl/trace_pkg.sv
// Shared types for the retirement trace: record layout, decode class and
// the valid-tagged stage slot used by the pipeline shadow.
package trace_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_R    = 2'b01,
        CLS_I    = 2'b10,
        CLS_J    = 2'b11
    } instr_class_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  instr;
        instr_class_e cls;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [31:0]  rs_val;
        logic [31:0]  rt_val;
        logic [31:0]  dest_val;
    } trace_rec_t;

    typedef struct packed {
        logic       valid;
        trace_rec_t rec;
    } stage_slot_t;

    // An ambiguous decode (zero or several flags) is recorded as no class.
    function automatic instr_class_e encode_class(input logic r, input logic i, input logic j);
        case ({r, i, j})
            3'b100:  return CLS_R;
            3'b010:  return CLS_I;
            3'b001:  return CLS_J;
            default: return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with a valid/ready head. A push while full is accepted only
// when the head is popped on the same edge; otherwise the caller sees a drop.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  trace_rec_t             push_data,
    input  logic                   pop_ready,
    output logic                   head_valid,
    output trace_rec_t             head_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    trace_rec_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic           pop;
    logic           do_push;

    assign head_valid = (count != '0);
    assign full       = (count == LW'(DEPTH));
    assign pop        = head_valid && pop_ready;
    assign do_push    = push && (!full || pop);
    assign level      = count;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the count gates visibility and the head is forced to zero when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/retire_trace_gen.sv
// Shadows the 5-stage pipeline with valid-tagged slots and emits one trace
// record per retired instruction through a small FIFO.
module retire_trace_gen
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [31:0]            pc_fetch,
    input  logic [31:0]            instr_fetch,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   is_r_type_iss,
    input  logic                   is_i_type_iss,
    input  logic                   is_j_type_iss,
    input  logic [4:0]             rs_iss,
    input  logic [4:0]             rt_iss,
    input  logic [4:0]             rd_iss,
    input  logic [31:0]            rs_val_ex,
    input  logic [31:0]            rt_val_ex,
    input  logic                   instr_retired_wb,
    input  logic                   reg_wr_wb,
    input  logic [31:0]            wr_data_wb,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [31:0]            trace_instr,
    output logic [1:0]             trace_type,
    output logic [4:0]             trace_rs,
    output logic [4:0]             trace_rt,
    output logic [4:0]             trace_rd,
    output logic [31:0]            trace_rs_val,
    output logic [31:0]            trace_rt_val,
    output logic [31:0]            trace_dest_val,
    output logic                   trace_overflow,
    output logic                   trace_proto_err,
    output logic [CNT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    stage_slot_t iss_q, ex_q, mem_q, wb_q;
    stage_slot_t iss_d, ex_d, mem_d, wb_d;
    trace_rec_t  push_rec, head_rec;
    logic        push, pop, full, dropped;

    assign push    = instr_retired_wb && wb_q.valid;
    assign pop     = trace_valid && trace_ready;
    assign dropped = push && full && !pop;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        iss_d = iss_q;
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        push_rec          = wb_q.rec;
        push_rec.dest_val = reg_wr_wb ? wr_data_wb : '0;
        if (!stall) begin
            iss_d           = '0;
            iss_d.valid     = fetch_valid;
            iss_d.rec.pc    = pc_fetch;
            iss_d.rec.instr = instr_fetch;
            ex_d            = iss_q;
            ex_d.rec.cls    = encode_class(is_r_type_iss, is_i_type_iss, is_j_type_iss);
            ex_d.rec.rs     = rs_iss;
            ex_d.rec.rt     = rt_iss;
            ex_d.rec.rd     = rd_iss;
            mem_d            = ex_q;
            mem_d.rec.rs_val = rs_val_ex;
            mem_d.rec.rt_val = rt_val_ex;
            wb_d             = mem_q;
        end else if (push) begin
            // A retired slot must not be recorded twice while the pipe is held.
            wb_d.valid = 1'b0;
        end
        if (flush) begin
            iss_d.valid = 1'b0;
            ex_d.valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q           <= '0;
            ex_q            <= '0;
            mem_q           <= '0;
            wb_q            <= '0;
            trace_overflow  <= 1'b0;
            trace_proto_err <= 1'b0;
            drop_count      <= '0;
        end else begin
            iss_q <= iss_d;
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (instr_retired_wb && !wb_q.valid) trace_proto_err <= 1'b1;
            if (dropped) begin
                trace_overflow <= 1'b1;
                if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_rec),
        .pop_ready (trace_ready),
        .head_valid(trace_valid),
        .head_data (head_rec),
        .full      (full),
        .level     (fifo_level)
    );

    assign trace_pc       = head_rec.pc;
    assign trace_instr    = head_rec.instr;
    assign trace_type     = head_rec.cls;
    assign trace_rs       = head_rec.rs;
    assign trace_rt       = head_rec.rt;
    assign trace_rd       = head_rec.rd;
    assign trace_rs_val   = head_rec.rs_val;
    assign trace_rt_val   = head_rec.rt_val;
    assign trace_dest_val = head_rec.dest_val;

endmodule

// File: tb/tb_retire_trace_gen.sv
// Directed bench for retire_trace_gen: a stage-list and record-queue model
// is compared every cycle, and literal expectations pin key scenarios.
module tb_retire_trace_gen;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              fetch_valid;
    logic [31:0]       pc_fetch, instr_fetch;
    logic              stall, flush;
    logic              is_r_type_iss, is_i_type_iss, is_j_type_iss;
    logic [4:0]        rs_iss, rt_iss, rd_iss;
    logic [31:0]       rs_val_ex, rt_val_ex;
    logic              instr_retired_wb, reg_wr_wb;
    logic [31:0]       wr_data_wb;
    logic              trace_valid, trace_ready;
    logic [31:0]       trace_pc, trace_instr;
    logic [1:0]        trace_type;
    logic [4:0]        trace_rs, trace_rt, trace_rd;
    logic [31:0]       trace_rs_val, trace_rt_val, trace_dest_val;
    logic              trace_overflow, trace_proto_err;
    logic [CNT_W-1:0]  drop_count;
    logic [LW-1:0]     fifo_level;

    retire_trace_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .pc_fetch(pc_fetch), .instr_fetch(instr_fetch),
        .stall(stall), .flush(flush),
        .is_r_type_iss(is_r_type_iss), .is_i_type_iss(is_i_type_iss), .is_j_type_iss(is_j_type_iss),
        .rs_iss(rs_iss), .rt_iss(rt_iss), .rd_iss(rd_iss),
        .rs_val_ex(rs_val_ex), .rt_val_ex(rt_val_ex),
        .instr_retired_wb(instr_retired_wb), .reg_wr_wb(reg_wr_wb), .wr_data_wb(wr_data_wb),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_type(trace_type),
        .trace_rs(trace_rs), .trace_rt(trace_rt), .trace_rd(trace_rd),
        .trace_rs_val(trace_rs_val), .trace_rt_val(trace_rt_val), .trace_dest_val(trace_dest_val),
        .trace_overflow(trace_overflow), .trace_proto_err(trace_proto_err),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  ty;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv, dv;
    } mrec_t;

    typedef struct packed {
        logic  v;
        mrec_t r;
    } mslot_t;

    mslot_t      m_iss, m_ex, m_mem, m_wb;
    mrec_t       m_q[$];
    bit          m_ovf, m_perr, started;
    int          m_drops;
    int          dut_pops;
    logic [31:0] last_pop_pc, last_pop_dest;
    bit          g_ready = 1'b1;
    bit          g_regwr = 1'b1;
    bit          g_multi = 1'b0;

    function automatic logic [1:0] class_of(input logic r, input logic i, input logic j);
        int n;
        n = int'(r) + int'(i) + int'(j);
        if (n != 1) return 2'd0;
        if (r) return 2'd1;
        if (i) return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_step();
        mrec_t rec;
        bit    pop, push;
        if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
            dut_pops++;
            last_pop_pc   = trace_pc;
            last_pop_dest = trace_dest_val;
        end
        if (reset) begin
            m_iss = '0; m_ex = '0; m_mem = '0; m_wb = '0;
            m_q.delete();
            m_ovf = 0; m_perr = 0; m_drops = 0;
            started = 1;
            return;
        end
        if (!started) return;
        pop  = (m_q.size() > 0) && trace_ready;
        push = instr_retired_wb && m_wb.v;
        if (instr_retired_wb && !m_wb.v) m_perr = 1;
        rec    = m_wb.r;
        rec.dv = reg_wr_wb ? wr_data_wb : 32'h0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(rec);
            else begin
                m_ovf = 1;
                if (m_drops < (1 << CNT_W) - 1) m_drops++;
            end
        end
        if (!stall) begin
            m_wb        = m_mem;
            m_mem       = m_ex;
            m_mem.r.rsv = rs_val_ex;
            m_mem.r.rtv = rt_val_ex;
            m_ex        = m_iss;
            m_ex.r.ty   = class_of(is_r_type_iss, is_i_type_iss, is_j_type_iss);
            m_ex.r.rs   = rs_iss;
            m_ex.r.rt   = rt_iss;
            m_ex.r.rd   = rd_iss;
            m_iss         = '0;
            m_iss.v       = fetch_valid;
            m_iss.r.pc    = pc_fetch;
            m_iss.r.instr = instr_fetch;
        end else if (push) begin
            m_wb.v = 0;
        end
        if (flush) begin
            m_iss.v = 0;
            m_ex.v  = 0;
        end
    endtask

    task automatic compare();
        mrec_t h;
        h = '0;
        if (m_q.size() > 0) h = m_q[0];
        check("valid",     32'(trace_valid), 32'(m_q.size() > 0));
        check("pc",        trace_pc, h.pc);
        check("instr",     trace_instr, h.instr);
        check("type",      32'(trace_type), 32'(h.ty));
        check("rs",        32'(trace_rs), 32'(h.rs));
        check("rt",        32'(trace_rt), 32'(h.rt));
        check("rd",        32'(trace_rd), 32'(h.rd));
        check("rs_val",    trace_rs_val, h.rsv);
        check("rt_val",    trace_rt_val, h.rtv);
        check("dest_val",  trace_dest_val, h.dv);
        check("level",     32'(fifo_level), 32'(m_q.size()));
        check("overflow",  32'(trace_overflow), 32'(m_ovf));
        check("proto_err", 32'(trace_proto_err), 32'(m_perr));
        check("drops",     32'(drop_count), 32'(m_drops));
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (started) compare();
    end

    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl, input logic ret, input logic [31:0] wd);
        logic [5:0] op;
        @(negedge clk);
        reset            = 1'b0;
        fetch_valid      = fv;
        pc_fetch         = pc;
        instr_fetch      = ins;
        stall            = st;
        flush            = fl;
        instr_retired_wb = ret;
        reg_wr_wb        = g_regwr;
        wr_data_wb       = wd;
        trace_ready      = g_ready;
        op               = m_iss.r.instr[31:26];
        is_r_type_iss    = g_multi || (op == 6'd0);
        is_j_type_iss    = g_multi || (op == 6'd2) || (op == 6'd3);
        is_i_type_iss    = g_multi || !((op == 6'd0) || (op == 6'd2) || (op == 6'd3));
        rs_iss           = m_iss.r.instr[25:21];
        rt_iss           = m_iss.r.instr[20:16];
        rd_iss           = m_iss.r.instr[15:11];
        rs_val_ex        = m_ex.r.instr ^ 32'hA5A5_0000;
        rt_val_ex        = m_ex.r.pc + 32'h1000;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic ret);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ret, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b1;
        fetch_valid      = 1'b0;
        instr_retired_wb = 1'b0;
        stall            = 1'b0;
        flush            = 1'b0;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] prog4 [6] = '{32'h012A_4020, 32'h8D09_0004, 32'h0C00_0040,
                              32'h2108_0001, 32'h0109_5022, 32'h3C01_1234};

    initial begin
        int p0;
        reset = 1'b1; fetch_valid = 0; pc_fetch = 0; instr_fetch = 0; stall = 0; flush = 0;
        is_r_type_iss = 0; is_i_type_iss = 0; is_j_type_iss = 0;
        rs_iss = 0; rt_iss = 0; rd_iss = 0; rs_val_ex = 0; rt_val_ex = 0;
        instr_retired_wb = 0; reg_wr_wb = 0; wr_data_wb = 0; trace_ready = 1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 32'(trace_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // Single addi: fetched in cycle 0, retires in cycle 4, visible in cycle 5.
        step(1'b1, 32'h0, 32'h2008_000A, 0, 0, 0, 0);
        idle(3, 1'b0);
        check("t1_not_yet", 32'(trace_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 0, 0, 1, 32'hA);
        check("t1_valid", 32'(trace_valid), 32'd1);
        check("t1_pc",    trace_pc, 32'h0);
        check("t1_instr", trace_instr, 32'h2008_000A);
        check("t1_type",  32'(trace_type), 32'd2);
        check("t1_rt",    32'(trace_rt), 32'd8);
        check("t1_dest",  trace_dest_val, 32'hA);
        idle(2, 1'b0);

        // Stall for three cycles while the add sits in execute.
        p0 = dut_pops;
        step(1'b1, 32'h40, 32'h0109_5020, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1'b0, 0, 0, 1, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0);
        check("t2_not_yet", 32'(trace_valid), 32'd0);
        step(1'b0, 0, 0, 0, 0, 1, 32'h55);
        check("t2_valid",  32'(trace_valid), 32'd1);
        check("t2_pc",     trace_pc, 32'h40);
        check("t2_type",   32'(trace_type), 32'd1);
        check("t2_rd",     32'(trace_rd), 32'd10);
        check("t2_rs_val", trace_rs_val, 32'hA4AC_5020);
        check("t2_rt_val", trace_rt_val, 32'h1040);
        check("t2_dest",   trace_dest_val, 32'h55);
        idle(3, 1'b0);
        check("t2_one_rec", 32'(dut_pops - p0), 32'd1);

        // Flush with A in execute, B in issue, C at fetch; retire every cycle afterwards.
        p0 = dut_pops;
        step(1'b1, 32'h80, 32'h2009_0003, 0, 0, 0, 0);
        step(1'b1, 32'h84, 32'h0800_0010, 0, 0, 0, 0);
        step(1'b1, 32'h88, 32'h2108_0001, 0, 1, 0, 0);
        g_regwr = 1'b0;
        repeat (4) step(1'b0, 0, 0, 0, 0, 1, 32'h33);
        g_regwr = 1'b1;
        check("t3_proto_err", 32'(trace_proto_err), 32'd1);
        check("t3_one_rec",   32'(dut_pops - p0), 32'd1);
        check("t3_pop_pc",    last_pop_pc, 32'h80);
        check("t3_pop_dest",  last_pop_dest, 32'h0);

        // Flush together with stall kills the instruction held in issue.
        p0 = dut_pops;
        step(1'b1, 32'hC0, 32'h2108_0001, 0, 0, 0, 0);
        step(1'b1, 32'hC4, 32'h2108_0002, 1, 1, 0, 0);
        idle(5, 1'b0);
        check("t3b_no_rec", 32'(dut_pops - p0), 32'd0);

        // Six back-to-back retires into a stalled consumer.
        g_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            g_multi = (c == 4);
            step(c < 6, 32'h100 + 32'(4 * (c % 6)), prog4[c % 6], 0, 0, c >= 4, 32'h1000 + 32'(c));
        end
        g_multi = 1'b0;
        check("t4_level", 32'(fifo_level), 32'd4);
        check("t4_drops", 32'(drop_count), 32'd2);
        check("t4_ovf",   32'(trace_overflow), 32'd1);
        g_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_drain_pc", trace_pc, 32'h100 + 32'(4 * k));
            if (k == 2) check("t4_type_j", 32'(trace_type), 32'd3);
            if (k == 3) check("t4_type_multi", 32'(trace_type), 32'd0);
            idle(1, 1'b0);
        end
        check("t4_empty", 32'(trace_valid), 32'd0);

        // Full FIFO with simultaneous pop and push.
        g_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            g_ready = (c == 8);
            step(c < 5, 32'h200 + 32'(4 * c), 32'h2008_0000 + 32'(c), 0, 0, c >= 4, 32'h2000 + 32'(c));
        end
        check("t5_level", 32'(fifo_level), 32'd4);
        check("t5_drops", 32'(drop_count), 32'd2);
        check("t5_head",  trace_pc, 32'h204);
        g_ready = 1'b1;
        idle(5, 1'b0);

        // Reset with three buffered records and more in flight.
        g_ready = 1'b0;
        for (int c = 0; c < 7; c++)
            step(c < 5, 32'h300 + 32'(4 * c), 32'h0109_5020, 0, 0, c >= 4, 32'h3000 + 32'(c));
        check("t6_level_pre", 32'(fifo_level), 32'd3);
        do_reset();
        check("t6_valid",     32'(trace_valid), 32'd0);
        check("t6_level",     32'(fifo_level), 32'd0);
        check("t6_ovf",       32'(trace_overflow), 32'd0);
        check("t6_proto_err", 32'(trace_proto_err), 32'd0);
        check("t6_drops",     32'(drop_count), 32'd0);
        g_ready = 1'b1;
        idle(3, 1'b1);
        check("t6_no_inflight", 32'(fifo_level), 32'd0);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retire_trace_gen.md
Name: retire_trace_gen

Overview:
- DUT-side producer of the per-instruction retirement trace consumed by the pipeline checker; the producing end of the checker interface.
- Shadows the 5-stage MIPS pipeline (fetch/issue/execute/memory/write-back) with its own valid-tagged stage registers.
- Assembles one record per retired instruction and buffers records in a small FIFO behind a valid/ready stream.
- Instantiated beside the core in top; the testbench drains the stream instead of probing hierarchical signals.

Parameters:
- DEPTH, 4, trace FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the dropped-record counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  pc_fetch/instr_fetch hold a real instruction
- pc_fetch  in  32  fetch-stage PC
- instr_fetch  in  32  fetch-stage instruction word
- stall  in  1  whole pipeline holds this cycle
- flush  in  1  kill instructions in issue and execute
- is_r_type_iss / is_i_type_iss / is_j_type_iss  in  1 each  decode class in issue
- rs_iss / rt_iss / rd_iss  in  5 each  register indices in issue
- rs_val_ex / rt_val_ex  in  32 each  operand values in execute
- instr_retired_wb  in  1  core retires the write-back instruction this cycle
- reg_wr_wb  in  1  write-back writes the register file
- wr_data_wb  in  32  register-file write data
- trace_valid  out  1  FIFO head holds a record
- trace_ready  in  1  consumer accepts the head
- trace_pc / trace_instr  out  32 each  record PC and instruction
- trace_type  out  2  class: 00 none, 01 R, 10 I, 11 J
- trace_rs / trace_rt / trace_rd  out  5 each  record register indices
- trace_rs_val / trace_rt_val / trace_dest_val  out  32 each  operand and destination values
- trace_overflow  out  1  sticky: a record was dropped
- trace_proto_err  out  1  sticky: retire seen with no valid write-back slot
- drop_count  out  CNT_W  dropped-record count, saturating
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: every stage valid bit 0, FIFO empty, trace_valid=0, all trace_* data outputs 0, trace_overflow=0, trace_proto_err=0, drop_count=0, fifo_level=0.
- Reset mid-stream discards all in-flight and buffered records.
- Advance when stall=0:
  - iss <= {fetch_valid, pc, instr}.
  - ex <= iss plus type and rs/rt/rd.
  - mem <= ex plus rs_val_ex/rt_val_ex.
  - wb <= mem.
- stall=1: every stage holds, including its valid bit.
- flush=1 clears the valid bits that would be loaded into iss and ex on that edge. flush overrides stall for those two bits only. mem and wb are unaffected.
- Type encoding from issue flags: R=01, I=10, J=11, none=00. More than one flag set encodes as 00.
- Record push when instr_retired_wb=1 and wb_valid=1:
  - dest_val = reg_wr_wb ? wr_data_wb : 0.
  - After the push edge, wb_valid clears unless a new instruction advanced into wb on the same edge.
- instr_retired_wb=1 with wb_valid=0: no push; set trace_proto_err.
- Latency: an instruction fetched in cycle N with no stalls retires in cycle N+4. trace_valid rises in cycle N+5 if the FIFO was empty.
- FIFO:
  - Pop when trace_valid && trace_ready.
  - Head data stays stable while trace_valid=1 and trace_ready=0.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle, full or not: both succeed, level unchanged.
  - Push when full with no pop: record dropped, trace_overflow set, drop_count increments and saturates at all-ones.
  - Pop when empty is ignored.
- trace_overflow and trace_proto_err clear only on reset.

Decomposition:
- Shared package trace_pkg holds:
  - trace_rec_t packed struct (pc, instr, type, rs, rt, rd, rs_val, rt_val, dest_val);
  - instr_class_e (NONE/R/I/J);
  - a stage-slot struct {valid, trace_rec_t}.
- One sub-module: trace_fifo (parameterised DEPTH, carries trace_rec_t, valid/ready output, full/level outputs).
- Stage shadowing and record assembly stay in retire_trace_gen.

Test Plan:
- Single addi (0x2008000A, pc 0x0), R/I flags from decode, no stall, retire with wr_data_wb=0xA -> trace_valid in cycle 5; record {pc 0x0, type 10, rt 8, dest_val 0xA}.
- stall held high for 3 cycles while the instruction is in ex -> record appears 3 cycles later; fields unchanged; exactly one record.
- flush while instructions are in iss and ex, then retire_wb asserted in each following cycle -> no records for the killed instructions; trace_proto_err=1.
- trace_ready=0 with 6 back-to-back retires, DEPTH=4 -> fifo_level=4, drop_count=2, trace_overflow=1; drained records are the first 4 in order.
- FIFO full with trace_ready=1 and a retire in the same cycle -> push accepted, level stays 4, drop_count unchanged.
- reset asserted with 3 buffered records -> next cycle trace_valid=0, fifo_level=0, sticky flags 0.
